// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, memory and status signals of the two-port memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              r0_req_valid;
    logic              r0_req_ready;
    logic [ADDR_W-1:0] r0_addr;
    logic              r0_we;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_rsp_valid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req_valid;
    logic              r1_req_ready;
    logic [ADDR_W-1:0] r1_addr;
    logic              r1_we;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_rsp_valid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [15:0]       conflict_cnt;

    // Arbiter side
    modport slave (
        input  r0_req_valid, r0_addr, r0_we, r0_wdata,
        input  r1_req_valid, r1_addr, r1_we, r1_wdata,
        input  mem_rdata,
        output r0_req_ready, r0_rsp_valid, r0_rdata,
        output r1_req_ready, r1_rsp_valid, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output conflict_cnt
    );

    // Requesters and memory side
    modport master (
        output r0_req_valid, r0_addr, r0_we, r0_wdata,
        output r1_req_valid, r1_addr, r1_we, r1_wdata,
        output mem_rdata,
        input  r0_req_ready, r0_rsp_valid, r0_rdata,
        input  r1_req_ready, r1_rsp_valid, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter; MEM_ARB_RR_EN selects round-robin, else port 1 fixed priority
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_next_q, rr_next_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    logic              any_valid;
    logic              both_valid;
    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Winner selection; rr_next_q stays 1 in the fixed-priority build so port 1 wins conflicts there
    always_comb begin
        any_valid  = bus.r0_req_valid | bus.r1_req_valid;
        both_valid = bus.r0_req_valid & bus.r1_req_valid;
        if (both_valid) begin
            win = rr_next_q;
        end else begin
            win = bus.r1_req_valid;
        end
        sel_we    = win ? bus.r1_we    : bus.r0_we;
        sel_addr  = win ? bus.r1_addr  : bus.r0_addr;
        sel_wdata = win ? bus.r1_wdata : bus.r0_wdata;
    end

    // Next state and all outputs; outputs are forced to zero while rst is high
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_next_d      = rr_next_q;
        conflict_cnt_d = conflict_cnt_q;
        bus.r0_req_ready = 1'b0;
        bus.r1_req_ready = 1'b0;
        bus.r0_rsp_valid = 1'b0;
        bus.r1_rsp_valid = 1'b0;
        bus.r0_rdata     = '0;
        bus.r1_rdata     = '0;
        bus.mem_en       = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    bus.r0_req_ready = ~win;
                    bus.r1_req_ready = win;
                    bus.mem_en       = 1'b1;
                    bus.mem_we       = sel_we;
                    bus.mem_addr     = sel_addr;
                    bus.mem_wdata    = sel_wdata;
                    if (!sel_we) begin
                        state_d = RESP;
                        owner_d = win;
                    end
`ifdef MEM_ARB_RR_EN
                    rr_next_d = ~rr_next_q;
`else
                    rr_next_d = 1'b1;
`endif
                end
                if (both_valid && (conflict_cnt_q != 16'hFFFF)) begin
                    conflict_cnt_d = conflict_cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (owner_q) begin
                    bus.r1_rsp_valid = 1'b1;
                    bus.r1_rdata     = bus.mem_rdata;
                end else begin
                    bus.r0_rsp_valid = 1'b1;
                    bus.r0_rdata     = bus.mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            bus.r0_req_ready = 1'b0;
            bus.r1_req_ready = 1'b0;
            bus.r0_rsp_valid = 1'b0;
            bus.r1_rsp_valid = 1'b0;
            bus.r0_rdata     = '0;
            bus.r1_rdata     = '0;
            bus.mem_en       = 1'b0;
            bus.mem_we       = 1'b0;
            bus.mem_addr     = '0;
            bus.mem_wdata    = '0;
        end
    end

    assign bus.conflict_cnt = conflict_cnt_q;

    // State register; reset abandons any outstanding read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            rr_next_q      <= 1'b1;
            conflict_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rr_next_q      <= rr_next_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, sets the read/write data width.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rN_req_valid  in  1  (N=0 fetch, N=1 load/store) request present.
REQ-006 rN_req_ready  out  1  request accepted this cycle (combinational).
REQ-007 rN_addr  in  ADDR_W  word address; rN_we  in  1  write=1/read=0; rN_wdata  in  DATA_W  write data.
REQ-008 rN_rsp_valid  out  1  read data valid pulse; rN_rdata  out  DATA_W  read data.
REQ-009 mem_en  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  drive the shared single-port memory.
REQ-010 mem_rdata  in  DATA_W  memory read data, valid the cycle after a read with mem_en=1, mem_we=0.
REQ-011 conflict_cnt  out  16  saturating count of cycles where both requesters are valid in IDLE.

Function
REQ-012 FSM states: IDLE, RESP; only one read outstanding at a time.
REQ-013 IDLE: if any rN_req_valid, select one winner, assert its rN_req_ready, and drive mem_en=1 with the winner's addr/we/wdata in the same cycle.
REQ-014 IDLE with no valid request: all ready=0, mem_en=0, mem_we=0, state stays IDLE.
REQ-015 Winner read: latch owner id, go to RESP; winner write: stay IDLE, write completes in that cycle with no response.
REQ-016 RESP: assert r<owner>_rsp_valid=1 for exactly one cycle with r<owner>_rdata=mem_rdata, all ready=0, mem_en=0, next state IDLE.
REQ-017 Read throughput is one per 2 cycles; write throughput is one per cycle; read latency from accept to rsp_valid is 1 cycle.
REQ-018 Requesters hold valid and payload stable until ready; deasserting valid before ready withdraws the request with no memory access.
REQ-019 The non-owner's rsp_valid stays 0; rN_rdata is 0 when rN_rsp_valid=0.
REQ-020 rsp_valid has no backpressure; the requester must accept it.
REQ-021 Single valid requester is always granted in IDLE regardless of priority state.
REQ-022 conflict_cnt increments when r0_req_valid=r1_req_valid=1 in IDLE, holds at 16'hFFFF.

Reset
REQ-023 rst=1 forces, asynchronously: state IDLE, all ready/rsp_valid/mem_en/mem_we=0, mem_addr/mem_wdata/rdata=0, conflict_cnt=0, rr_next=1.
REQ-024 Reset during RESP abandons the read; no rsp_valid is produced after rst deasserts.
REQ-025 First grant is possible in the first cycle after rst deasserts.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: round-robin; on conflict, the port indicated by rr_next wins, and rr_next flips to the other port on every grant.
REQ-027 MEM_ARB_RR_EN undefined: fixed priority; port 1 always wins conflicts, rr_next is unused and held at 1.

Verification
REQ-028 r1 read addr 0x10, memory holds 0xDEADBEEF -> cycle 0 r1_req_ready=1, mem_en=1, mem_we=0; cycle 1 r1_rsp_valid=1, r1_rdata=0xDEADBEEF.
REQ-029 r0 writes 0x5A5A5A5A to 0x04, then r0 reads 0x04 -> write accepted in 1 cycle without response, read returns 0x5A5A5A5A one cycle after accept.
REQ-030 Both valid reads, held 4 grants, RR build -> grant order 1,0,1,0 and conflict_cnt=4 with only IDLE cycles counted; fixed build -> order 1,1,1,1 with r0 starved.
REQ-031 rst pulsed in RESP after r0 read accept -> no r0_rsp_valid after release, state IDLE, conflict_cnt=0.
REQ-032 Both valid for 70000 IDLE cycles -> conflict_cnt saturates at 0xFFFF.
